// File: rtl/exc_commit_pkg.sv
// Shared definitions for the exception commit unit: flag bit indices, final codes
// handed to CP0, CP0 field positions and the FSM / BadVAddr-select encodings.
package exc_commit_pkg;

    localparam int EXC_W = 15;

    // Raw exception flag bit positions within exc_flags_i.
    // A single ADEL flag covers both fetch and data address errors; a misaligned
    // PC identifies the fetch case.
    localparam int EXCF_ADEL        = 0;
    localparam int EXCF_TLBRL_CODE  = 1;
    localparam int EXCF_TLBIL_CODE  = 2;
    localparam int EXCF_INSTINVALID = 3;
    localparam int EXCF_SYSCALL     = 4;
    localparam int EXCF_BREAK       = 5;
    localparam int EXCF_TRAP        = 6;
    localparam int EXCF_OVERFLOW    = 7;
    localparam int EXCF_ADES        = 8;
    localparam int EXCF_TLBRL_DATA  = 9;
    localparam int EXCF_TLBRS       = 10;
    localparam int EXCF_TLBIL_DATA  = 11;
    localparam int EXCF_TLBIS       = 12;
    localparam int EXCF_TLBM        = 13;
    localparam int EXCF_ERET        = 14;

    // Final codes shared with CP0. Code/data variants of a TLB fault share a code.
    localparam logic [31:0] NOEXC_FINAL       = 32'h0000_0000;
    localparam logic [31:0] INTERRUPT_FINAL   = 32'h0000_0001;
    localparam logic [31:0] ADEL_FINAL        = 32'h0000_0004;
    localparam logic [31:0] ADES_FINAL        = 32'h0000_0005;
    localparam logic [31:0] SYSCALL_FINAL     = 32'h0000_0008;
    localparam logic [31:0] BREAK_FINAL       = 32'h0000_0009;
    localparam logic [31:0] INSTINVALID_FINAL = 32'h0000_000A;
    localparam logic [31:0] OVERFLOW_FINAL    = 32'h0000_000C;
    localparam logic [31:0] TRAP_FINAL        = 32'h0000_000D;
    localparam logic [31:0] ERET_FINAL        = 32'h0000_000E;
    localparam logic [31:0] TLBRL_FINAL       = 32'h0000_0020;
    localparam logic [31:0] TLBIL_FINAL       = 32'h0000_0021;
    localparam logic [31:0] TLBRS_FINAL       = 32'h0000_0022;
    localparam logic [31:0] TLBIS_FINAL       = 32'h0000_0023;
    localparam logic [31:0] TLBM_FINAL        = 32'h0000_0024;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_LO      = 8;
    localparam int IM_HI      = 15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BVA_NONE = 2'd0,
        BVA_PC   = 2'd1,
        BVA_ADDR = 2'd2
    } bva_sel_t;

    function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
        return status[STATUS_IE] & ~status[STATUS_EXL]
               & (|(status[IM_HI:IM_LO] & cause[IM_HI:IM_LO]));
    endfunction

endpackage

// File: rtl/exc_commit_prio_enc.sv
// Combinational priority encoder: picks the winning exception and where its
// BadVAddr comes from.
module exc_prio_enc
    import exc_commit_pkg::*;
(
    input  logic             int_pending,
    input  logic [EXC_W-1:0] exc_flags,
    input  logic             fetch_misaligned,
    output logic [31:0]      code,
    output bva_sel_t         bva_sel
);

    logic adel_fetch;
    logic adel_data;

    assign adel_fetch = exc_flags[EXCF_ADEL] & fetch_misaligned;
    assign adel_data  = exc_flags[EXCF_ADEL] & ~fetch_misaligned;

    always_comb begin
        code    = NOEXC_FINAL;
        bva_sel = BVA_NONE;
        if (int_pending) begin
            code = INTERRUPT_FINAL;
        end else if (adel_fetch) begin
            code    = ADEL_FINAL;
            bva_sel = BVA_PC;
        end else if (exc_flags[EXCF_TLBRL_CODE]) begin
            code    = TLBRL_FINAL;
            bva_sel = BVA_PC;
        end else if (exc_flags[EXCF_TLBIL_CODE]) begin
            code    = TLBIL_FINAL;
            bva_sel = BVA_PC;
        end else if (exc_flags[EXCF_INSTINVALID]) begin
            code = INSTINVALID_FINAL;
        end else if (exc_flags[EXCF_SYSCALL]) begin
            code = SYSCALL_FINAL;
        end else if (exc_flags[EXCF_BREAK]) begin
            code = BREAK_FINAL;
        end else if (exc_flags[EXCF_TRAP]) begin
            code = TRAP_FINAL;
        end else if (exc_flags[EXCF_OVERFLOW]) begin
            code = OVERFLOW_FINAL;
        end else if (adel_data) begin
            code    = ADEL_FINAL;
            bva_sel = BVA_ADDR;
        end else if (exc_flags[EXCF_ADES]) begin
            code    = ADES_FINAL;
            bva_sel = BVA_ADDR;
        end else if (exc_flags[EXCF_TLBRL_DATA]) begin
            code    = TLBRL_FINAL;
            bva_sel = BVA_ADDR;
        end else if (exc_flags[EXCF_TLBRS]) begin
            code    = TLBRS_FINAL;
            bva_sel = BVA_ADDR;
        end else if (exc_flags[EXCF_TLBIL_DATA]) begin
            code    = TLBIL_FINAL;
            bva_sel = BVA_ADDR;
        end else if (exc_flags[EXCF_TLBIS]) begin
            code    = TLBIS_FINAL;
            bva_sel = BVA_ADDR;
        end else if (exc_flags[EXCF_TLBM]) begin
            code    = TLBM_FINAL;
            bva_sel = BVA_ADDR;
        end else if (exc_flags[EXCF_ERET]) begin
            code = ERET_FINAL;
        end
    end

endmodule

// File: rtl/exc_commit.sv
// Exception commit unit: latches the winning exception in MEM, waits for the data
// bus to drain, hands one code to CP0 for a cycle, then flushes and redirects.
module exc_commit
    import exc_commit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter logic [31:0] REFILL_VECTOR = 32'hBFC00200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_in_delayslot_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [EXC_W-1:0] exc_flags_i,
    input  logic [31:0]      status_i,
    input  logic [31:0]      cause_i,
    input  logic [31:0]      epc_i,
    input  logic             bus_busy_i,
    output logic             stall_o,
    output logic [31:0]      excepttype_o,
    output logic [31:0]      current_inst_addr_o,
    output logic             is_in_delayslot_o,
    output logic [31:0]      badvaddr_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o
);

    state_t      state_reg;
    logic [31:0] code_reg;
    logic [31:0] pc_reg;
    logic        ds_reg;
    logic [31:0] bva_reg;
    logic        refill_reg;

    logic        int_pend;
    logic [31:0] enc_code;
    bva_sel_t    enc_bva_sel;
    logic [31:0] bva_next;
    logic        refill_next;
    logic        detect;

    // Only IE/EXL/IM and IP fields participate; the rest is reduced away here.
    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    assign int_pend = int_pending(status_i, cause_i);

    exc_prio_enc u_prio_enc (
        .int_pending      (int_pend),
        .exc_flags        (exc_flags_i),
        .fetch_misaligned (|mem_pc_i[1:0]),
        .code             (enc_code),
        .bva_sel          (enc_bva_sel)
    );

    always_comb begin
        bva_next = 32'h0;
        case (enc_bva_sel)
            BVA_PC:   bva_next = mem_pc_i;
            BVA_ADDR: bva_next = mem_addr_i;
            default:  bva_next = 32'h0;
        endcase
    end

    assign refill_next = ((enc_code == TLBRL_FINAL) || (enc_code == TLBRS_FINAL))
                         & ~status_i[STATUS_EXL];

    assign detect = (state_reg == ST_IDLE) && mem_valid_i
                    && (enc_code != NOEXC_FINAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            code_reg   <= NOEXC_FINAL;
            pc_reg     <= 32'h0;
            ds_reg     <= 1'b0;
            bva_reg    <= 32'h0;
            refill_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (detect) begin
                        code_reg   <= enc_code;
                        pc_reg     <= mem_pc_i;
                        ds_reg     <= mem_in_delayslot_i;
                        bva_reg    <= bva_next;
                        refill_reg <= refill_next;
                        state_reg  <= bus_busy_i ? ST_DRAIN : ST_COMMIT;
                    end
                end
                ST_DRAIN: begin
                    if (!bus_busy_i) begin
                        state_reg <= ST_COMMIT;
                    end
                end
                ST_COMMIT:   state_reg <= ST_REDIRECT;
                ST_REDIRECT: state_reg <= ST_IDLE;
                default:     state_reg <= ST_IDLE;
            endcase
        end
    end

    assign stall_o = detect || (state_reg == ST_DRAIN) || (state_reg == ST_COMMIT);

    assign excepttype_o        = (state_reg == ST_COMMIT) ? code_reg : NOEXC_FINAL;
    assign current_inst_addr_o = (state_reg == ST_COMMIT) ? pc_reg   : 32'h0;
    assign is_in_delayslot_o   = (state_reg == ST_COMMIT) ? ds_reg   : 1'b0;
    assign badvaddr_o          = (state_reg == ST_COMMIT) ? bva_reg  : 32'h0;

    // epc_i is taken live in REDIRECT so an ERET sees the value CP0 holds after COMMIT.
    assign flush_o  = (state_reg == ST_REDIRECT);
    assign new_pc_o = (state_reg != ST_REDIRECT) ? 32'h0 :
                      (code_reg == ERET_FINAL)   ? epc_i :
                      refill_reg                 ? REFILL_VECTOR : EXC_VECTOR;

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: one exception sequence per transaction, checked
// cycle by cycle against hand-derived values.
module tb_exc_commit;
    import exc_commit_pkg::*;

    logic             clk;
    logic             rst;
    logic             mem_valid_i;
    logic [31:0]      mem_pc_i;
    logic             mem_in_delayslot_i;
    logic [31:0]      mem_addr_i;
    logic [EXC_W-1:0] exc_flags_i;
    logic [31:0]      status_i;
    logic [31:0]      cause_i;
    logic [31:0]      epc_i;
    logic             bus_busy_i;
    logic             stall_o;
    logic [31:0]      excepttype_o;
    logic [31:0]      current_inst_addr_o;
    logic             is_in_delayslot_o;
    logic [31:0]      badvaddr_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;

    int checks   = 0;
    int failures = 0;

    exc_commit dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_addr_i          (mem_addr_i),
        .exc_flags_i         (exc_flags_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .bus_busy_i          (bus_busy_i),
        .stall_o             (stall_o),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .badvaddr_o          (badvaddr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Full exception sequence: detect, nb DRAIN cycles, COMMIT, REDIRECT, back to IDLE.
    // On the last DRAIN cycle a fresh syscall is presented; it must be ignored.
    task automatic run_exc(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                           input logic ds, input logic [EXC_W-1:0] flags,
                           input logic [31:0] status, input logic [31:0] cause,
                           input logic [31:0] epc, input int nb,
                           input logic [31:0] exp_code, input logic [31:0] exp_bva,
                           input logic [31:0] exp_newpc);
        tick();
        mem_valid_i        = 1'b1;
        mem_pc_i           = pc;
        mem_addr_i         = addr;
        mem_in_delayslot_i = ds;
        exc_flags_i        = flags;
        status_i           = status;
        cause_i            = cause;
        epc_i              = epc;
        bus_busy_i         = (nb > 0);
        #1;
        chk({tag, ".detect_stall"}, {31'h0, stall_o}, 32'h1);
        chk({tag, ".detect_code"}, excepttype_o, NOEXC_FINAL);
        tick();
        mem_valid_i = 1'b0;
        exc_flags_i = '0;
        for (int i = 1; i <= nb; i++) begin
            if (i == nb) begin
                bus_busy_i  = 1'b0;
                mem_valid_i = 1'b1;
                exc_flags_i = EXC_W'(1) << EXCF_SYSCALL;
            end
            #1;
            chk({tag, ".drain_stall"}, {31'h0, stall_o}, 32'h1);
            chk({tag, ".drain_code"}, excepttype_o, NOEXC_FINAL);
            tick();
            mem_valid_i = 1'b0;
            exc_flags_i = '0;
        end
        #1;
        chk({tag, ".commit_code"}, excepttype_o, exp_code);
        chk({tag, ".commit_pc"}, current_inst_addr_o, pc);
        chk({tag, ".commit_ds"}, {31'h0, is_in_delayslot_o}, {31'h0, ds});
        chk({tag, ".commit_bva"}, badvaddr_o, exp_bva);
        chk({tag, ".commit_stall"}, {31'h0, stall_o}, 32'h1);
        chk({tag, ".commit_flush"}, {31'h0, flush_o}, 32'h0);
        tick();
        #1;
        chk({tag, ".redir_flush"}, {31'h0, flush_o}, 32'h1);
        chk({tag, ".redir_newpc"}, new_pc_o, exp_newpc);
        chk({tag, ".redir_stall"}, {31'h0, stall_o}, 32'h0);
        chk({tag, ".redir_code"}, excepttype_o, NOEXC_FINAL);
        tick();
        #1;
        chk({tag, ".idle_flush"}, {31'h0, flush_o}, 32'h0);
        chk({tag, ".idle_stall"}, {31'h0, stall_o}, 32'h0);
        status_i = 32'h0;
        cause_i  = 32'h0;
        $display("txn %s code=0x%08h bva=0x%08h new_pc=0x%08h drain=%0d",
                 tag, exp_code, exp_bva, exp_newpc, nb);
    endtask

    initial begin
        rst                = 1'b1;
        mem_valid_i        = 1'b0;
        mem_pc_i           = 32'h0;
        mem_in_delayslot_i = 1'b0;
        mem_addr_i         = 32'h0;
        exc_flags_i        = '0;
        status_i           = 32'h0;
        cause_i            = 32'h0;
        epc_i              = 32'h0;
        bus_busy_i         = 1'b0;

        tick();
        tick();
        chk("reset.stall", {31'h0, stall_o}, 32'h0);
        chk("reset.flush", {31'h0, flush_o}, 32'h0);
        chk("reset.newpc", new_pc_o, 32'h0);
        chk("reset.code", excepttype_o, NOEXC_FINAL);
        chk("reset.bva", badvaddr_o, 32'h0);
        $display("txn reset");
        rst = 1'b0;

        run_exc("syscall", 32'h8000_1000, 32'h0, 1'b0, EXC_W'(1) << EXCF_SYSCALL,
                32'h0, 32'h0, 32'h0, 0, SYSCALL_FINAL, 32'h0, 32'hBFC0_0380);
        run_exc("tlbrl_data_exl0", 32'h8000_1100, 32'h0040_3ABC, 1'b0,
                EXC_W'(1) << EXCF_TLBRL_DATA, 32'h0, 32'h0, 32'h0, 3,
                TLBRL_FINAL, 32'h0040_3ABC, 32'hBFC0_0200);
        run_exc("tlbrl_data_exl1", 32'h8000_1100, 32'h0040_3ABC, 1'b0,
                EXC_W'(1) << EXCF_TLBRL_DATA, 32'h0000_0002, 32'h0, 32'h0, 0,
                TLBRL_FINAL, 32'h0040_3ABC, 32'hBFC0_0380);
        run_exc("int_over_ovf", 32'h8000_1200, 32'h0, 1'b1, EXC_W'(1) << EXCF_OVERFLOW,
                32'h0000_0401, 32'h0000_0400, 32'h0, 0,
                INTERRUPT_FINAL, 32'h0, 32'hBFC0_0380);
        run_exc("eret", 32'h8000_1300, 32'h0, 1'b0, EXC_W'(1) << EXCF_ERET,
                32'h0, 32'h0, 32'h8000_2000, 0, ERET_FINAL, 32'h0, 32'h8000_2000);
        run_exc("adel_fetch", 32'h8000_1002, 32'h0000_1234, 1'b0,
                (EXC_W'(1) << EXCF_ADEL) | (EXC_W'(1) << EXCF_TLBM),
                32'h0, 32'h0, 32'h0, 1, ADEL_FINAL, 32'h8000_1002, 32'hBFC0_0380);
        run_exc("ovf_over_adel_data", 32'h8000_1004, 32'h0000_0013, 1'b0,
                (EXC_W'(1) << EXCF_ADEL) | (EXC_W'(1) << EXCF_OVERFLOW),
                32'h0, 32'h0, 32'h0, 0, OVERFLOW_FINAL, 32'h0, 32'hBFC0_0380);
        run_exc("adel_data_over_tlbm", 32'h8000_1008, 32'h0000_0013, 1'b0,
                (EXC_W'(1) << EXCF_ADEL) | (EXC_W'(1) << EXCF_TLBM),
                32'h0, 32'h0, 32'h0, 0, ADEL_FINAL, 32'h0000_0013, 32'hBFC0_0380);
        run_exc("tlbil_code", 32'h8000_100C, 32'h0000_5555, 1'b0,
                (EXC_W'(1) << EXCF_TLBIL_CODE) | (EXC_W'(1) << EXCF_TLBM),
                32'h0, 32'h0, 32'h0, 0, TLBIL_FINAL, 32'h8000_100C, 32'hBFC0_0380);

        // Reset while draining: sequence aborts, no flush follows.
        tick();
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h8000_1400;
        exc_flags_i = EXC_W'(1) << EXCF_SYSCALL;
        bus_busy_i  = 1'b1;
        #1;
        chk("rst_drain.detect_stall", {31'h0, stall_o}, 32'h1);
        tick();
        mem_valid_i = 1'b0;
        exc_flags_i = '0;
        #1;
        chk("rst_drain.drain_stall", {31'h0, stall_o}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_drain.after_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_drain.after_code", excepttype_o, NOEXC_FINAL);
        chk("rst_drain.after_flush", {31'h0, flush_o}, 32'h0);
        rst        = 1'b0;
        bus_busy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_drain.no_flush", {31'h0, flush_o}, 32'h0);
            chk("rst_drain.no_code", excepttype_o, NOEXC_FINAL);
        end
        $display("txn rst_during_drain");

        // Interrupt pending but MEM invalid: nothing happens.
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        #1;
        chk("int_invalid.stall", {31'h0, stall_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("int_invalid.code", excepttype_o, NOEXC_FINAL);
            chk("int_invalid.flush", {31'h0, flush_o}, 32'h0);
        end
        status_i = 32'h0;
        cause_i  = 32'h0;
        $display("txn int_with_mem_invalid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_commit.md
# exc_commit

Exception commit unit sitting between the MEM stage and the CP0 register file. It prioritises the raw exception flags and the pending-interrupt condition of the instruction in MEM, and drains any outstanding data-bus transaction. It then presents one final exception code (with EPC source, delay-slot bit and BadVAddr) to CP0 for exactly one cycle, and issues the pipeline flush and redirect PC one cycle later.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380: general exception entry (BEV=1).
- REFILL_VECTOR, 32'hBFC00200: TLB refill entry, used when Status.EXL=0.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset: synchronous, active-high (`RstEnable`).
- mem_valid_i  in  1  MEM holds a valid, uncancelled instruction.
- mem_pc_i  in  32  PC of that instruction.
- mem_in_delayslot_i  in  1  instruction is in a branch delay slot.
- mem_addr_i  in  32  data virtual address of that instruction.
- exc_flags_i  in  15  raw exception flags; bit indices defined in defines.v.
- status_i  in  32  CP0 Status (IE bit 0, EXL bit 1, IM bits 15:8).
- cause_i  in  32  CP0 Cause (IP bits 15:8).
- epc_i  in  32  CP0 EPC.
- bus_busy_i  in  1  data-bus transaction in flight.
- stall_o  out  1  freeze IF..MEM.
- excepttype_o  out  32  final code to CP0; `NOEXC_FINAL` when idle.
- current_inst_addr_o  out  32  PC to CP0.
- is_in_delayslot_o  out  1  delay-slot bit to CP0.
- badvaddr_o  out  32  BadVAddr to CP0.
- flush_o  out  1  flush all pipeline registers.
- new_pc_o  out  32  redirect target, valid with flush_o.

## Operation
- Interrupt pending: status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]).
- Detection happens only in IDLE with mem_valid_i=1. Candidates are the interrupt-pending condition and exc_flags_i.
- Priority, highest first: INTERRUPT, fetch ADEL, TLBRL_CODE, TLBIL_CODE, INSTINVALID, SYSCALL, BREAK, TRAP, OVERFLOW, data ADEL, ADES, TLBRL_DATA, TLBRS, TLBIL_DATA, TLBIS, TLBM, ERET.
- BadVAddr source:
  - fetch ADEL, TLB*_CODE: mem_pc_i.
  - data ADEL/ADES, TLB*_DATA, TLBRS, TLBIS, TLBM: mem_addr_i.
  - all others: 0.
- At detection, latch the code, mem_pc_i, mem_in_delayslot_i and BadVAddr. Also latch is_refill = (TLBRL_* or TLBRS) & ~status_i[1].
- FSM:
  - IDLE: on detection, go to DRAIN if bus_busy_i=1, else go to COMMIT.
  - DRAIN: stay while bus_busy_i=1; go to COMMIT when it drops.
  - COMMIT: drive latched values on the CP0 outputs for exactly one cycle; go to REDIRECT.
  - REDIRECT: flush_o=1. new_pc_o is epc_i for ERET (sampled this cycle, after any CP0 write), REFILL_VECTOR if is_refill, else EXC_VECTOR. Then go to IDLE.
- stall_o = 1 combinationally in IDLE on the detection cycle, and in DRAIN and COMMIT. stall_o = 0 in REDIRECT, where flush_o takes over.
- Inputs are ignored outside IDLE. No second exception is latched until the FSM returns to IDLE.
- Outside COMMIT: excepttype_o = `NOEXC_FINAL`; current_inst_addr_o, is_in_delayslot_o and badvaddr_o are 0.

## Timing
- Reset: state IDLE, latches cleared, stall_o=0, flush_o=0, new_pc_o=0, excepttype_o=`NOEXC_FINAL`.
- Reset asserted mid-sequence aborts the sequence on the next edge. No flush is issued.
- No-drain latency: detect at cycle N, COMMIT at N+1, REDIRECT at N+2, IDLE at N+3.
- Each DRAIN cycle adds one cycle of latency.
- The CP0 write occurs on the edge that ends COMMIT.
- If bus_busy_i deasserts and a new detection condition is present on the same cycle in DRAIN, the FSM still goes to COMMIT with the original latched exception.
- If mem_valid_i=0, nothing is detected even when interrupts are pending.

## Structure
- defines.v holds: the exception-flag bit indices (`EXCF_*`), the *_FINAL codes (shared with CP0), the FSM state encoding, and the Status/Cause field positions.
- One natural sub-module: exc_prio_enc, a combinational priority encoder from (int_pending, exc_flags) to {final code, BadVAddr select}. The FSM and latches remain in exc_commit.

## Test plan
- Syscall flag, pc=0x80001000, bus idle: excepttype_o=`SYSCALL_FINAL` at N+1, flush_o=1 at N+2, new_pc_o=0xBFC00380, stall_o=1 for cycles N..N+1.
- Data TLB refill on load (TLBRL_DATA), mem_addr=0x00403ABC, EXL=0, bus_busy_i high for 3 cycles: 3 DRAIN cycles; badvaddr_o=0x00403ABC; new_pc_o=0xBFC00200.
- Same exception with EXL=1: new_pc_o=0xBFC00380.
- Interrupt pending (IE=1, IM2=1, IP2=1) together with OVERFLOW flag, delay slot set: excepttype_o=`INTERRUPT_FINAL`, is_in_delayslot_o=1.
- ERET flag, epc_i=0x80002000: excepttype_o=`ERET_FINAL`, then new_pc_o=0x80002000 with flush_o.
- rst asserted during DRAIN: next cycle IDLE, flush_o never asserted, excepttype_o=`NOEXC_FINAL`.
